prio_arbiter: RTL and testbench

Parametrised, registered successor to the team's combinational 8-to-3 priority encoder. Takes N request lines and issues one grant at a time with a valid/ready handshake. Priority is selectable per decision: fixed (highest index wins) or round-robin. Sits between request sources (interrupt lines, DMA channels) and a single shared consumer.

---
 rtl/arb_pkg.sv | 12 +
 rtl/prio_pick.sv | 56 +++++
 rtl/prio_arbiter.sv | 94 +++++++++
 tb/tb_prio_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the priority arbiter: the values of the mode input and the FSM state type.
package arb_pkg;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

endpackage

// File: rtl/prio_pick.sv
// Combinational picker: rotates req so the search starts just below 'start',
// takes the highest set bit, then maps the position back to a request index.
module prio_pick
    import arb_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    input  logic         mode,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] start_eff;
    logic [N-1:0] rot;
    logic [W-1:0] pos;

    // Fixed mode is the same search with no rotation.
    assign start_eff = (mode == ARB_RR) ? start : '0;

    // Put req[start-1] at the top of the rotated vector and req[start] at the bottom.
    always_comb begin : rotate
        int j;
        rot = '0;
        for (int k = 0; k < N; k++) begin
            j = k + int'(start_eff);
            if (j >= N) begin
                j = j - N;
            end
            rot[k] = req[j];
        end
    end

    always_comb begin
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            if (rot[i]) begin
                found = 1'b1;
                pos   = i[W-1:0];
            end
        end
    end

    always_comb begin : unrotate
        int sum;
        sum = int'(pos) + int'(start_eff);
        if (sum >= N) begin
            sum = sum - N;
        end
        idx = sum[W-1:0];
    end

endmodule

// File: rtl/prio_arbiter.sv
// Registered N-way arbiter with a valid/ready grant handshake.
// Supports fixed (highest index wins) and round-robin priority.
module prio_arbiter
    import arb_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         mode,
    input  logic [N-1:0] req,
    input  logic         gnt_ready,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot,
    output logic         any_req
);

    arb_state_e   state;
    arb_state_e   next_state;
    logic [W-1:0] last;
    logic [W-1:0] next_last;
    logic [W-1:0] next_idx;
    logic [W-1:0] pick_start;
    logic         pick_found;
    logic [W-1:0] pick_idx;

    // A decision in GRANT only happens on accept, when the held index becomes the new pointer.
    assign pick_start = (state == ARB_GRANT) ? gnt_idx : last;

    prio_pick #(
        .N (N)
    ) u_pick (
        .req   (req),
        .start (pick_start),
        .mode  (mode),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign any_req   = enable & (|req);
    assign gnt_valid = (state == ARB_GRANT);

    always_comb begin
        gnt_onehot = '0;
        if (gnt_valid) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

    // Dropping enable aborts before any accept is considered, so the pointer stays put.
    always_comb begin
        next_state = state;
        next_idx   = gnt_idx;
        next_last  = last;
        if (!enable) begin
            next_state = ARB_IDLE;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        next_state = ARB_GRANT;
                        next_idx   = pick_idx;
                    end
                end
                ARB_GRANT: begin
                    if (gnt_ready) begin
                        next_last = gnt_idx;
                        if (pick_found) begin
                            next_idx = pick_idx;
                        end else begin
                            next_state = ARB_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            gnt_idx <= '0;
            last    <= '0;
        end else begin
            state   <= next_state;
            gnt_idx <= next_idx;
            last    <= next_last;
        end
    end

endmodule

// File: tb/tb_prio_arbiter.sv
// Bench for prio_arbiter: vector table with a scoreboard queue for N = 8,
// plus a hand-written round-robin sequence on an N = 3 instance.
module tb_prio_arbiter;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       mode;
    logic [7:0] req;
    logic       gnt_ready;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt_onehot;
    logic       any_req;

    logic       enable3;
    logic       mode3;
    logic [2:0] req3;
    logic       ready3;
    logic       valid3;
    logic [1:0] idx3;
    logic [2:0] onehot3;
    logic       any3;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       mode;
        logic [7:0] req;
        logic       rdy;
        logic       exp_valid;
        logic [2:0] exp_idx;
        logic       exp_any;
    } vec_t;

    typedef struct {
        logic       valid;
        logic       check_idx;
        logic [2:0] idx;
        logic       any;
    } exp_t;

    vec_t vecs[31];
    exp_t exp_q[$];

    prio_arbiter #(.N(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode       (mode),
        .req        (req),
        .gnt_ready  (gnt_ready),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot),
        .any_req    (any_req)
    );

    prio_arbiter #(.N(3)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable3),
        .mode       (mode3),
        .req        (req3),
        .gnt_ready  (ready3),
        .gnt_valid  (valid3),
        .gnt_idx    (idx3),
        .gnt_onehot (onehot3),
        .any_req    (any3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic r, input logic e, input logic m, input logic [7:0] q,
                                input logic rd, input logic ev, input logic [2:0] ei, input logic ea);
        vec_t v;
        v.rst_n = r; v.en = e; v.mode = m; v.req = q; v.rdy = rd;
        v.exp_valid = ev; v.exp_idx = ei; v.exp_any = ea;
        return v;
    endfunction

    task automatic checkValue(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        rst_n     = v.rst_n;
        enable    = v.en;
        mode      = v.mode;
        req       = v.req;
        gnt_ready = v.rdy;
        e.valid     = v.exp_valid;
        e.check_idx = v.exp_valid | ~v.rst_n;
        e.idx       = v.exp_idx;
        e.any       = v.exp_any;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input int step);
        exp_t e;
        logic [7:0] exp_onehot;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty step %0d: got 0 entries expected 1", step);
        end else begin
            e = exp_q.pop_front();
            exp_onehot = e.valid ? (8'h01 << e.idx) : 8'h00;
            checkValue($sformatf("valid[%0d]", step), int'(gnt_valid), int'(e.valid));
            checkValue($sformatf("onehot[%0d]", step), int'(gnt_onehot), int'(exp_onehot));
            checkValue($sformatf("any_req[%0d]", step), int'(any_req), int'(e.any));
            if (e.check_idx) begin
                checkValue($sformatf("idx[%0d]", step), int'(gnt_idx), int'(e.idx));
            end
        end
    endtask

    initial begin
        int cycles;
        int seq3[3];
        logic [2:0] exp_oh3;

        // reset, fixed priority, sticky hold, empty, rotation, wrap, abort, mid-grant reset
        vecs[0]  = mk(0, 0, 0, 8'hA1, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 8'hA1, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 8'hA1, 0, 1, 7, 1);
        vecs[3]  = mk(1, 1, 0, 8'h20, 1, 1, 5, 1);
        vecs[4]  = mk(1, 1, 0, 8'h01, 0, 1, 5, 1);
        vecs[5]  = mk(1, 1, 0, 8'h01, 0, 1, 5, 1);
        vecs[6]  = mk(1, 1, 0, 8'h01, 0, 1, 5, 1);
        vecs[7]  = mk(1, 1, 0, 8'h01, 0, 1, 5, 1);
        vecs[8]  = mk(1, 1, 0, 8'h01, 1, 1, 0, 1);
        vecs[9]  = mk(1, 1, 0, 8'h00, 1, 0, 0, 0);
        vecs[10] = mk(1, 1, 0, 8'h00, 0, 0, 0, 0);
        vecs[11] = mk(1, 1, 1, 8'hFF, 0, 1, 7, 1);
        vecs[12] = mk(1, 1, 1, 8'hFF, 1, 1, 6, 1);
        vecs[13] = mk(1, 1, 1, 8'hFF, 1, 1, 5, 1);
        vecs[14] = mk(1, 1, 1, 8'hFF, 1, 1, 4, 1);
        vecs[15] = mk(1, 1, 1, 8'hFF, 1, 1, 3, 1);
        vecs[16] = mk(1, 1, 1, 8'hFF, 1, 1, 2, 1);
        vecs[17] = mk(1, 1, 1, 8'hFF, 1, 1, 1, 1);
        vecs[18] = mk(1, 1, 1, 8'hFF, 1, 1, 0, 1);
        vecs[19] = mk(1, 1, 1, 8'hFF, 1, 1, 7, 1);
        vecs[20] = mk(1, 1, 1, 8'h04, 1, 1, 2, 1);
        vecs[21] = mk(1, 1, 1, 8'h0C, 1, 1, 3, 1);
        vecs[22] = mk(1, 1, 0, 8'h0C, 0, 1, 3, 1);
        vecs[23] = mk(1, 0, 1, 8'hFF, 1, 0, 0, 0);
        vecs[24] = mk(1, 1, 1, 8'h0C, 0, 1, 3, 1);
        vecs[25] = mk(1, 1, 0, 8'h0C, 1, 1, 3, 1);
        vecs[26] = mk(1, 1, 1, 8'h0C, 1, 1, 2, 1);
        vecs[27] = mk(0, 1, 1, 8'h0C, 0, 0, 0, 1);
        vecs[28] = mk(1, 1, 1, 8'h0C, 0, 1, 3, 1);
        vecs[29] = mk(1, 1, 1, 8'h0C, 1, 1, 2, 1);
        vecs[30] = mk(1, 1, 1, 8'h00, 1, 0, 0, 0);

        enable3 = 1'b0;
        mode3   = 1'b1;
        req3    = 3'b000;
        ready3  = 1'b0;

        for (int i = 0; i < 31; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(i);
        end

        // N = 3 round-robin: first grant after one cycle, then 2, 1, 0, 2 back-to-back
        enable3 = 1'b1;
        mode3   = 1'b1;
        req3    = 3'b111;
        ready3  = 1'b0;
        cycles  = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!valid3 && cycles < 5);
        checkValue("n3_first_latency", cycles, 1);
        checkValue("n3_first_idx", int'(idx3), 2);

        seq3[0] = 1;
        seq3[1] = 0;
        seq3[2] = 2;
        ready3 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp_oh3 = 3'b001 << seq3[k];
            checkValue($sformatf("n3_valid[%0d]", k), int'(valid3), 1);
            checkValue($sformatf("n3_idx[%0d]", k), int'(idx3), seq3[k]);
            checkValue($sformatf("n3_onehot[%0d]", k), int'(onehot3), int'(exp_oh3));
        end

        req3 = 3'b000;
        @(negedge clk);
        checkValue("n3_idle_valid", int'(valid3), 0);
        checkValue("n3_idle_any", int'(any3), 0);
        checkValue("n3_idle_onehot", int'(onehot3), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
